// File: rtl/video_fallback_pkg.sv
// Shared types and elaboration-time helpers for the video fallback switch.
package video_fallback_pkg;

  typedef enum logic [1:0] {
    FALLBACK = 2'd0,
    ACQUIRE  = 2'd1,
    ACTIVE   = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Total period of one axis from its four timing segments.
  function automatic int timing_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Counter width able to hold 0 .. total-1 (at least one bit).
  function automatic int cnt_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/video_fallback_switch_timing.sv
// Free-running raster counters with registered sync / data-enable decode.
module vga_timing_gen
  import video_fallback_pkg::*;
#(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  localparam int  H_TOTAL  = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int  V_TOTAL  = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int  HCNT_W   = cnt_width(H_TOTAL),
  localparam int  VCNT_W   = cnt_width(V_TOTAL)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              hs,
  output logic              vs,
  output logic              de,
  output logic [HCNT_W-1:0] hcnt,
  output logic [VCNT_W-1:0] vcnt
);

  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  // Raster position: pixel counter wraps per line, line counter advances on that wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == HCNT_W'(H_TOTAL - 1)) begin
      hcnt <= '0;
      vcnt <= (vcnt == VCNT_W'(V_TOTAL - 1)) ? '0 : vcnt + VCNT_W'(1);
    end else begin
      hcnt <= hcnt + HCNT_W'(1);
    end
  end

  // Sync and enable decode, one cycle behind the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs <= ~HS_POL;
      vs <= ~VS_POL;
      de <= 1'b0;
    end else begin
      hs <= (hcnt >= HCNT_W'(HS_START) && hcnt <= HCNT_W'(HS_END)) ? HS_POL : ~HS_POL;
      vs <= (vcnt >= VCNT_W'(VS_START) && vcnt <= VCNT_W'(VS_END)) ? VS_POL : ~VS_POL;
      de <= (hcnt < HCNT_W'(H_ACTIVE)) && (vcnt < VCNT_W'(V_ACTIVE));
    end
  end

endmodule

// File: rtl/video_fallback_switch.sv
// Selects between decoder video and a locally generated fill-colour raster,
// locking onto the decoder after a run of vsync edges and dropping back when
// decoder vsync stops.
module video_fallback_switch
  import video_fallback_pkg::*;
#(
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter logic        HS_POL     = 1'b1,
  parameter logic        VS_POL     = 1'b1,
  parameter int          LOCK_EDGES = 3,
  parameter int          TIMEOUT    = 1_000_000,
  parameter logic [23:0] FILL_RGB   = 24'hFFFFFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] core_r,
  input  logic [7:0] core_g,
  input  logic [7:0] core_b,
  input  logic       core_hs,
  input  logic       core_vs,
  input  logic       core_de,
  input  logic       force_fallback,
  output logic [7:0] out_r,
  output logic [7:0] out_g,
  output logic [7:0] out_b,
  output logic       out_hs,
  output logic       out_vs,
  output logic       out_de,
  output logic       core_active,
  output logic       lost_pulse
);

  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HCNT_W  = cnt_width(H_TOTAL);
  localparam int VCNT_W  = cnt_width(V_TOTAL);
  localparam int ECNT_W  = cnt_width(LOCK_EDGES + 1);
  localparam int TO_W    = cnt_width(TIMEOUT);

  logic              fb_hs_p0;
  logic              fb_vs_p0;
  logic              fb_de_p0;
  logic [HCNT_W-1:0] fb_hcnt;
  logic [VCNT_W-1:0] fb_vcnt;
  logic              fb_cnt_unused;
  rgb_t              fb_rgb_p0;
  rgb_t              core_rgb_p0;

  state_e            state;
  logic [ECNT_W-1:0] edge_cnt;
  logic [ECNT_W-1:0] edge_cnt_inc;
  logic [TO_W-1:0]   to_cnt;
  logic              vs_q;
  logic              vs_edge;
  logic              to_hit;

  rgb_t              rgb_p1;
  logic              hs_p1;
  logic              vs_p1;
  logic              de_p1;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HS_POL   (HS_POL),
    .VS_POL   (VS_POL)
  ) u_timing (
    .clk  (clk),
    .rst  (rst),
    .hs   (fb_hs_p0),
    .vs   (fb_vs_p0),
    .de   (fb_de_p0),
    .hcnt (fb_hcnt),
    .vcnt (fb_vcnt)
  );

  // Raster position is exported by the generator for debug taps; the mux only needs the decode.
  assign fb_cnt_unused = ^{fb_hcnt, fb_vcnt};

  assign fb_rgb_p0   = fb_de_p0 ? rgb_t'(FILL_RGB) : rgb_t'('0);
  assign core_rgb_p0 = {core_r, core_g, core_b};

  assign vs_edge      = (vs_q != VS_POL) && (core_vs == VS_POL);
  assign to_hit       = (to_cnt == TO_W'(TIMEOUT - 1));
  assign edge_cnt_inc = edge_cnt + ECNT_W'(1);
  assign core_active  = (state == ACTIVE);

  // Previous core vsync level for edge detection; idles at the inactive level.
  always_ff @(posedge clk) begin
    if (rst) vs_q <= ~VS_POL;
    else     vs_q <= core_vs;
  end

  // Lock FSM: count vsync edges to lock, watch for vsync loss once acquiring.
  always_ff @(posedge clk) begin
    if (rst || force_fallback) begin
      state      <= FALLBACK;
      edge_cnt   <= '0;
      to_cnt     <= '0;
      lost_pulse <= 1'b0;
    end else begin
      lost_pulse <= 1'b0;
      case (state)
        FALLBACK: begin
          to_cnt <= '0;
          if (vs_edge) begin
            edge_cnt <= ECNT_W'(1);
            state    <= (LOCK_EDGES == 1) ? ACTIVE : ACQUIRE;
          end
        end
        ACQUIRE, ACTIVE: begin
          // An edge in the timeout cycle still counts as activity.
          if (vs_edge) begin
            to_cnt <= '0;
            if (state == ACQUIRE) begin
              edge_cnt <= edge_cnt_inc;
              if (edge_cnt_inc == ECNT_W'(LOCK_EDGES)) state <= ACTIVE;
            end
          end else if (to_hit) begin
            state      <= FALLBACK;
            edge_cnt   <= '0;
            to_cnt     <= '0;
            lost_pulse <= (state == ACTIVE);
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: begin
          state    <= FALLBACK;
          edge_cnt <= '0;
          to_cnt   <= '0;
        end
      endcase
    end
  end

  // Stage p0 -> p1: single output register shared by both paths; no frame alignment on switch.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_p1 <= '0;
      hs_p1  <= ~HS_POL;
      vs_p1  <= ~VS_POL;
      de_p1  <= 1'b0;
    end else if (core_active) begin
      rgb_p1 <= core_rgb_p0;
      hs_p1  <= core_hs;
      vs_p1  <= core_vs;
      de_p1  <= core_de;
    end else begin
      rgb_p1 <= fb_rgb_p0;
      hs_p1  <= fb_hs_p0;
      vs_p1  <= fb_vs_p0;
      de_p1  <= fb_de_p0;
    end
  end

  assign out_r  = rgb_p1.r;
  assign out_g  = rgb_p1.g;
  assign out_b  = rgb_p1.b;
  assign out_hs = hs_p1;
  assign out_vs = vs_p1;
  assign out_de = de_p1;

endmodule

// File: tb/tb_video_fallback_switch.sv
// Directed bench for video_fallback_switch using a shrunken raster (16x8) and short timeout.
module tb_video_fallback_switch;

  localparam int HA = 8, HF = 2, HSY = 3, HB = 3;
  localparam int VA = 4, VF = 1, VSY = 2, VB = 1;
  localparam int HT = 16, VT = 8;
  localparam int TO = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] core_r, core_g, core_b;
  logic       core_hs, core_vs, core_de, core_vs2, force_fb;

  logic [7:0] o1_r, o1_g, o1_b, o2_r, o2_g, o2_b;
  logic       o1_hs, o1_vs, o1_de, act1, lost1;
  logic       o2_hs, o2_vs, o2_de, act2, lost2;
  logic [26:0] o1, o2;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  int last_edge = 0;

  assign o1 = {o1_r, o1_g, o1_b, o1_hs, o1_vs, o1_de};
  assign o2 = {o2_r, o2_g, o2_b, o2_hs, o2_vs, o2_de};

  always #5 clk = ~clk;

  video_fallback_switch #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .TIMEOUT(TO)
  ) dut1 (
    .clk(clk), .rst(rst),
    .core_r(core_r), .core_g(core_g), .core_b(core_b),
    .core_hs(core_hs), .core_vs(core_vs), .core_de(core_de),
    .force_fallback(force_fb),
    .out_r(o1_r), .out_g(o1_g), .out_b(o1_b),
    .out_hs(o1_hs), .out_vs(o1_vs), .out_de(o1_de),
    .core_active(act1), .lost_pulse(lost1)
  );

  video_fallback_switch #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .TIMEOUT(TO), .LOCK_EDGES(1), .VS_POL(1'b0)
  ) dut2 (
    .clk(clk), .rst(rst),
    .core_r(core_r), .core_g(core_g), .core_b(core_b),
    .core_hs(core_hs), .core_vs(core_vs2), .core_de(core_de),
    .force_fallback(1'b0),
    .out_r(o2_r), .out_g(o2_g), .out_b(o2_b),
    .out_hs(o2_hs), .out_vs(o2_vs), .out_de(o2_de),
    .core_active(act2), .lost_pulse(lost2)
  );

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Expected fallback output n cycles after reset release (two-register latency from counters).
  function automatic logic [26:0] fb_exp(input int n, input logic vpol);
    int p, h, v;
    logic hs, vs, de;
    if (n < 2) return {24'h0, 1'b0, ~vpol, 1'b0};
    p  = n - 2;
    h  = p % HT;
    v  = (p / HT) % VT;
    de = (h < HA) && (v < VA);
    hs = (h >= HA + HF) && (h <= HA + HF + HSY - 1);
    vs = ((v >= VA + VF) && (v <= VA + VF + VSY - 1)) ? vpol : ~vpol;
    return {(de ? 24'hFFFFFF : 24'h0), hs, vs, de};
  endfunction

  // One-cycle rising pulse on dut1 core vsync; the edge is sampled on this tick.
  task automatic vs_pulse();
    core_vs = 1'b1;
    tick();
    last_edge = cyc;
    core_vs = 1'b0;
  endtask

  logic [26:0] vec [4];
  logic any_lost;
  int e;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = {24'h123456, 3'b101};
    vec[1] = {24'hA5A5A5, 3'b010};
    vec[2] = {24'h00FF00, 3'b100};
    vec[3] = {24'hFEDCBA, 3'b001};

    rst = 1'b1; force_fb = 1'b0;
    core_r = 8'h12; core_g = 8'h34; core_b = 8'h56;
    core_hs = 1'b1; core_vs = 1'b0; core_de = 1'b1; core_vs2 = 1'b1;
    repeat (3) tick();
    check("reset_out1", o1, 27'h0);
    check("reset_out2", o2, {24'h0, 3'b010});
    check("reset_act1", act1, 0);
    check("reset_lost1", lost1, 0);
    cyc = 0;
    rst = 1'b0;

    // Test 1: fallback raster, two frames, both polarities
    repeat (2 * HT * VT + 4) begin
      tick();
      check("fb_frame1", o1, fb_exp(cyc, 1'b1));
      check("fb_frame2", o2, fb_exp(cyc, 1'b0));
    end
    check("fb_act2", act2, 0);

    // Test 2: lock after three rising edges, then 1-cycle pass-through
    vs_pulse(); check("lock_e1", act1, 0);
    repeat (4) tick();
    vs_pulse(); check("lock_e2", act1, 0);
    repeat (4) tick();
    check("lock_wait", act1, 0);
    vs_pulse(); check("lock_e3", act1, 1);
    check("switch_lag", o1, fb_exp(cyc, 1'b1));
    for (int i = 0; i < 4; i++) begin
      {core_r, core_g, core_b, core_hs, core_vs, core_de} = vec[i];
      tick();
      check("core_pass", o1, vec[i]);
    end
    check("lock_hold", act1, 1);

    // Test 3: loss of vsync while ACTIVE
    tick();
    vs_pulse();
    e = last_edge;
    {core_r, core_g, core_b, core_hs, core_vs, core_de} = {24'h123456, 3'b101};
    while (cyc < e + TO - 1) tick();
    check("pre_to_act", act1, 1);
    check("pre_to_lost", lost1, 0);
    tick();
    check("to_lost", lost1, 1);
    check("to_act", act1, 0);
    check("to_out_core", o1, {24'h123456, 3'b101});
    tick();
    check("to_lost_end", lost1, 0);
    check("to_out_fb", o1, fb_exp(cyc, 1'b1));

    // Test 4: two edges then stall -> silent return, three fresh edges to lock
    vs_pulse(); check("acq_e1", act1, 0);
    tick();
    vs_pulse(); check("acq_e2", act1, 0);
    any_lost = 1'b0;
    repeat (TO + 20) begin
      tick();
      any_lost |= lost1;
    end
    check("acq_to_nolost", any_lost, 0);
    check("acq_to_act", act1, 0);
    tick(); vs_pulse(); check("relock_e1", act1, 0);
    tick(); vs_pulse(); check("relock_e2", act1, 0);
    tick(); vs_pulse(); check("relock_e3", act1, 1);

    // Test 5: force_fallback while ACTIVE
    force_fb = 1'b1;
    tick(); check("force_act", act1, 0);
    tick(); check("force_out_fb", o1, fb_exp(cyc, 1'b1));
    vs_pulse(); check("force_edge_ign", act1, 0);
    tick();
    force_fb = 1'b0;
    tick(); vs_pulse(); check("force_e1", act1, 0);
    tick(); vs_pulse(); check("force_e2", act1, 0);
    tick(); vs_pulse(); check("force_e3", act1, 1);

    // Test 6a: reset mid-ACTIVE, raster restarts at 0,0
    {core_r, core_g, core_b, core_hs, core_vs, core_de} = {24'hABCDEF, 3'b101};
    rst = 1'b1;
    tick();
    check("mid_rst_out1", o1, 27'h0);
    check("mid_rst_act1", act1, 0);
    check("mid_rst_lost1", lost1, 0);
    check("mid_rst_out2", o2, {24'h0, 3'b010});
    cyc = 0;
    rst = 1'b0;
    repeat (40) begin
      tick();
      check("restart1", o1, fb_exp(cyc, 1'b1));
      check("restart2", o2, fb_exp(cyc, 1'b0));
    end

    // Test 6b: LOCK_EDGES=1, VS_POL=0 locks on a single falling edge
    check("pol_idle_act2", act2, 0);
    check("pol_idle_act1", act1, 0);
    core_vs2 = 1'b0;
    tick();
    check("pol_lock_act2", act2, 1);
    tick();
    check("pol_pass2", o2, {24'hABCDEF, 3'b101});

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
